ff_ref_checker: RTL and testbench
=================================

Name: ff_ref_checker

Overview:
- Downstream self-checking stage for single-bit flip-flop testbenches: consumes the DUT stimulus (data, clear) and the DUT output, and runs a cycle-accurate golden DFF-with-clear model.
- Compares the DUT output against the model on every rising edge, counts checks and mismatches, and records the first failing check index.
- Replaces free-running per-edge assertion prints with a counted, gated PASS/FAIL verdict that the bench can read at end of run.

Parameters:
- WARMUP, 2, rising edges after an enabled start during which no comparison is made.
- NUM_CHECKS, 10000, comparisons after which the run completes.
- CNT_W, 16, width of the check, error and first-error counters. Must satisfy 2^CNT_W > NUM_CHECKS.
- STOP_ON_FAIL, 0. When 1, the first mismatch ends checking immediately.

Ports:
- clk  input  1  sampling clock, shared with the DUT; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  check enable, level; starts the run and pauses it.
- d  input  1  data driven into the DUT.
- clr  input  1  active-high clear driven into the DUT.
- q  input  1  DUT output under check.
- busy  output  1  high in WARMUP or CHECK.
- done  output  1  sticky run-complete flag.
- fail  output  1  sticky; high once any mismatch is counted.
- pass  output  1  equals done AND NOT fail.
- chk_cnt  output  CNT_W  number of comparisons performed.
- err_cnt  output  CNT_W  number of mismatches; saturates at all-ones.
- first_err  output  CNT_W  chk_cnt value at the first mismatch; all-ones if there has been none.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; ref_q=0; ref_vld=0; warm counter=0.
  - busy=0, done=0, fail=0, pass=0, chk_cnt=0, err_cnt=0, first_err=all-ones.
- Golden model, evaluated every rising edge in any state except IDLE:
  - If clr=1: ref_q<=0 and ref_vld<=1.
  - Otherwise: ref_q<=d and ref_vld<=1.
  - clr is sampled only at the edge. Bench rule: clear pulses must span at least one rising edge.
- Compare at an edge:
  - A check happens when state=CHECK, en=1, ref_vld=1 and clr=0.
  - The sampled DUT q is compared with ref_q as it was before this edge's update.
  - Result: one cycle of DUT latency is matched by the model.
- Clear handling:
  - An edge with clr=1 is never checked.
  - The next edge compares q against 0.
- States:
  - IDLE: en=1 at an edge -> WARMUP; the warm counter is cleared.
  - WARMUP: counts edges with en=1; en=0 holds the count. When the count reaches WARMUP -> CHECK. If WARMUP=0, go straight to CHECK.
  - CHECK:
    - Every check increments chk_cnt.
    - On a mismatch: err_cnt+1, saturating; fail<=1; if this is the first error, first_err<=chk_cnt (pre-increment value).
    - When chk_cnt reaches NUM_CHECKS -> DONE.
    - With STOP_ON_FAIL=1, a mismatch -> DONE on the same edge.
    - en=0 pauses: no checks, and counters hold.
  - DONE: done=1 and busy=0. All counters are frozen and no further checks occur. The state is left only by rst_n.
- Outputs are registered; pass is combinational from the done and fail registers.
- Boundary conditions:
  - q or d is X/Z at a check: counts as a mismatch.
  - Mismatch on the final (NUM_CHECKS-th) check: it is counted, then done=1 and pass=0.
  - err_cnt at all-ones: holds; fail stays 1.
  - rst_n asserted mid-run: all state and outputs return to reset values immediately, without waiting for clk.
  - clr=1 together with en rising in IDLE: WARMUP is entered and ref_q<=0.

Test Plan:
- Ideal DFF DUT with clear, d toggled every 3 time units, en=1, WARMUP=2, NUM_CHECKS=100 -> done=1, pass=1, chk_cnt=100, err_cnt=0, first_err=0xFFFF.
- Same DUT, but q forced inverted on check #37 only -> err_cnt=1, first_err=36, fail=1, pass=0 at done.
- clr held high for two edges mid-run, DUT correct -> 2 fewer checks than edges during that span, no error; the edge after clr release checks q=0.
- STOP_ON_FAIL=1, mismatch at check #5 -> done=1 on that edge, chk_cnt=5, err_cnt=1, all counters frozen afterwards.
- en dropped for 10 edges during CHECK -> chk_cnt unchanged across the gap and resumes incrementing; final chk_cnt=NUM_CHECKS.
- rst_n pulsed low between edges mid-run -> outputs go to reset values immediately; with en=1, a new run starts from IDLE on the next edge.

Source files
------------

// File: rtl/ff_ref_checker.sv
// Golden DFF-with-clear reference and counted comparator for single-bit flip-flop benches.
// Tracks checks, mismatches and the first failing check index; exposes a sticky pass/fail verdict.
module ff_ref_checker #(
    parameter int WARMUP       = 2,
    parameter int NUM_CHECKS   = 10000,
    parameter int CNT_W        = 16,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             d,
    input  logic             clr,
    input  logic             q,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic             pass,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err
);

    localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  NUM_CHK_C = CNT_W'(NUM_CHECKS);
    localparam logic [WARM_W-1:0] WARM_C    = WARM_W'(WARMUP);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_CHECK, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              ref_val_q, ref_val_d;
    logic              ref_vld_q, ref_vld_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [CNT_W-1:0]  chk_q, chk_d;
    logic [CNT_W-1:0]  err_q, err_d;
    logic [CNT_W-1:0]  ferr_q, ferr_d;
    logic              fail_q, fail_d;
    logic              mism;
    logic              check;

    always_comb begin
        state_d   = state_q;
        ref_val_d = ref_val_q;
        ref_vld_d = ref_vld_q;
        warm_d    = warm_q;
        chk_d     = chk_q;
        err_d     = err_q;
        ferr_d    = ferr_q;
        fail_d    = fail_q;

        // Written so that an unknown q or d falls through to a mismatch in simulation.
        mism = 1'b1;
        if ((q == ref_val_q) && ((d == 1'b0) || (d == 1'b1))) begin
            mism = 1'b0;
        end

        check = (state_q == S_CHECK) && en && ref_vld_q && !clr;

        // The model also runs on the starting edge so a clear seen there is honoured.
        if ((state_q != S_IDLE) || en) begin
            ref_vld_d = 1'b1;
            if (clr) begin
                ref_val_d = 1'b0;
            end else begin
                ref_val_d = d;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    warm_d  = '0;
                    state_d = (WARMUP == 0) ? S_CHECK : S_WARMUP;
                end
            end
            S_WARMUP: begin
                if (en) begin
                    warm_d = warm_q + 1'b1;
                    if (warm_d == WARM_C) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (check) begin
                    chk_d = chk_q + 1'b1;
                    if (mism) begin
                        fail_d = 1'b1;
                        if (err_q != CNT_MAX) begin
                            err_d = err_q + 1'b1;
                        end
                        if (!fail_q) begin
                            ferr_d = chk_q;
                        end
                    end
                    if ((chk_d == NUM_CHK_C) || (STOP_ON_FAIL && mism)) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ref_val_q <= 1'b0;
            ref_vld_q <= 1'b0;
            warm_q    <= '0;
            chk_q     <= '0;
            err_q     <= '0;
            ferr_q    <= '1;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_val_q <= ref_val_d;
            ref_vld_q <= ref_vld_d;
            warm_q    <= warm_d;
            chk_q     <= chk_d;
            err_q     <= err_d;
            ferr_q    <= ferr_d;
            fail_q    <= fail_d;
        end
    end

    assign busy      = (state_q == S_WARMUP) || (state_q == S_CHECK);
    assign done      = (state_q == S_DONE);
    assign fail      = fail_q;
    assign pass      = done && !fail_q;
    assign chk_cnt   = chk_q;
    assign err_cnt   = err_q;
    assign first_err = ferr_q;

endmodule

// File: tb/tb_ff_ref_checker.sv
// Bench for ff_ref_checker: an ideal DFF-with-clear feeds two checker instances
// (run-to-count and stop-on-fail); expected verdicts are queued and compared at completion.
module tb_ff_ref_checker;

    typedef struct {
        logic [15:0] chk;
        logic [15:0] err;
        logic [15:0] ferr;
        logic        pas;
        logic        fl;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        en_s = 1'b0;
    logic        d = 1'b0;
    logic        clr = 1'b0;
    logic        inj = 1'b0;
    logic        dut_ff;
    logic        q;

    logic        busy, done, fail, pass;
    logic [15:0] chk_cnt, err_cnt, first_err;
    logic        busy_s, done_s, fail_s, pass_s;
    logic [15:0] chk_cnt_s, err_cnt_s, first_err_s;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_i   = 0;
    res_t exp_q[$];
    res_t e;

    always #5 clk = ~clk;

    // Ideal DUT: synchronous clear, one cycle of latency; inj flips its output for one edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dut_ff <= 1'b0;
        else        dut_ff <= clr ? 1'b0 : d;
    end
    assign q = dut_ff ^ inj;

    ff_ref_checker #(.WARMUP(2), .NUM_CHECKS(100), .CNT_W(16), .STOP_ON_FAIL(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d), .clr(clr), .q(q),
        .busy(busy), .done(done), .fail(fail), .pass(pass),
        .chk_cnt(chk_cnt), .err_cnt(err_cnt), .first_err(first_err)
    );

    ff_ref_checker #(.WARMUP(2), .NUM_CHECKS(100), .CNT_W(16), .STOP_ON_FAIL(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en_s), .d(d), .clr(clr), .q(q),
        .busy(busy_s), .done(done_s), .fail(fail_s), .pass(pass_s),
        .chk_cnt(chk_cnt_s), .err_cnt(err_cnt_s), .first_err(first_err_s)
    );

    // Called at a falling edge; drives one rising edge and returns at the next falling edge.
    task automatic drive_edge(input bit e_v, input bit es_v, input bit c_v, input bit i_v, input int dv);
        en   = e_v;
        en_s = es_v;
        clr  = c_v;
        inj  = i_v;
        d    = (dv < 0) ? 1'($urandom_range(0, 1)) : 1'(dv);
        @(posedge clk);
        @(negedge clk);
        edge_i++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0; en_s = 1'b0; clr = 1'b0; inj = 1'b0;
        #1;
        rst_n = 1'b1;
        edge_i = 0;
    endtask

    task automatic test_reset();
        #17;
        n_checks++;
        if ({busy, done, fail, pass, chk_cnt, err_cnt, first_err} !== {4'b0000, 16'd0, 16'd0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL reset_main: got busy=%0b done=%0b fail=%0b pass=%0b chk=%0d err=%0d ferr=%h, want 0 0 0 0 0 0 ffff",
                     busy, done, fail, pass, chk_cnt, err_cnt, first_err);
        end
        n_checks++;
        if ({busy_s, done_s, fail_s, pass_s, chk_cnt_s, err_cnt_s, first_err_s} !== {4'b0000, 16'd0, 16'd0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL reset_stop: got busy=%0b done=%0b fail=%0b pass=%0b chk=%0d err=%0d ferr=%h, want 0 0 0 0 0 0 ffff",
                     busy_s, done_s, fail_s, pass_s, chk_cnt_s, err_cnt_s, first_err_s);
        end
        do_reset();
    endtask

    task automatic test_clean();
        do_reset();
        exp_q.push_back('{16'd100, 16'd0, 16'hFFFF, 1'b1, 1'b0});
        for (int k = 0; k < 300 && !done; k++) begin
            drive_edge(1'b1, 1'b0, 1'b0, 1'b0, -1);
            if (edge_i == 1) begin
                n_checks++;
                if (busy !== 1'b1 || chk_cnt !== 16'd0) begin
                    n_fail++;
                    $display("FAIL clean_start: got busy=%0b chk=%0d, want busy=1 chk=0", busy, chk_cnt);
                end
            end
            if (edge_i == 3) begin
                n_checks++;
                if (chk_cnt !== 16'd0) begin
                    n_fail++;
                    $display("FAIL clean_warmup: got chk=%0d after warmup edges, want 0", chk_cnt);
                end
            end
        end
        n_checks++;
        if (edge_i != 103) begin
            n_fail++;
            $display("FAIL clean_done_edge: got done after %0d edges, want 103", edge_i);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({chk_cnt, err_cnt, first_err, pass, fail, busy} !== {e.chk, e.err, e.ferr, e.pas, e.fl, 1'b0}) begin
            n_fail++;
            $display("FAIL clean_final: got chk=%0d err=%0d ferr=%h pass=%0b fail=%0b busy=%0b, want chk=%0d err=%0d ferr=%h pass=%0b fail=%0b busy=0",
                     chk_cnt, err_cnt, first_err, pass, fail, busy, e.chk, e.err, e.ferr, e.pas, e.fl);
        end
    endtask

    task automatic test_inject37();
        do_reset();
        exp_q.push_back('{16'd100, 16'd1, 16'd36, 1'b0, 1'b1});
        for (int k = 0; k < 300 && !done; k++) begin
            drive_edge(1'b1, 1'b0, 1'b0, edge_i == 39, -1);
            if (edge_i == 40) begin
                n_checks++;
                if ({fail, first_err, err_cnt, chk_cnt, done} !== {1'b1, 16'd36, 16'd1, 16'd37, 1'b0}) begin
                    n_fail++;
                    $display("FAIL inj37_at_edge: got fail=%0b ferr=%0d err=%0d chk=%0d done=%0b, want 1 36 1 37 0",
                             fail, first_err, err_cnt, chk_cnt, done);
                end
            end
        end
        n_checks++;
        if (edge_i != 103) begin
            n_fail++;
            $display("FAIL inj37_done_edge: got done after %0d edges, want 103", edge_i);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({chk_cnt, err_cnt, first_err, pass, fail} !== {e.chk, e.err, e.ferr, e.pas, e.fl}) begin
            n_fail++;
            $display("FAIL inj37_final: got chk=%0d err=%0d ferr=%0d pass=%0b fail=%0b, want chk=%0d err=%0d ferr=%0d pass=%0b fail=%0b",
                     chk_cnt, err_cnt, first_err, pass, fail, e.chk, e.err, e.ferr, e.pas, e.fl);
        end
    endtask

    task automatic test_clear();
        do_reset();
        exp_q.push_back('{16'd100, 16'd0, 16'hFFFF, 1'b1, 1'b0});
        // Clear spans edges 20-21 with d=1; the corrupted q on edge 20 must be ignored.
        for (int k = 0; k < 300 && !done; k++) begin
            drive_edge(1'b1, 1'b0, (edge_i == 20) || (edge_i == 21), edge_i == 20,
                       ((edge_i == 20) || (edge_i == 21)) ? 1 : -1);
            if (edge_i == 20 || edge_i == 22 || edge_i == 23 || edge_i == 26) begin
                n_checks++;
                if (chk_cnt !== ((edge_i == 20) ? 16'd17 : (edge_i == 26) ? 16'd21 : (edge_i == 23) ? 16'd18 : 16'd17)
                    || err_cnt !== 16'd0) begin
                    n_fail++;
                    $display("FAIL clear_count_e%0d: got chk=%0d err=%0d, want chk=%0d err=0", edge_i - 1, chk_cnt, err_cnt,
                             (edge_i == 20) ? 17 : (edge_i == 26) ? 21 : (edge_i == 23) ? 18 : 17);
                end
            end
        end
        n_checks++;
        if (edge_i != 105) begin
            n_fail++;
            $display("FAIL clear_done_edge: got done after %0d edges, want 105", edge_i);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({chk_cnt, err_cnt, first_err, pass, fail} !== {e.chk, e.err, e.ferr, e.pas, e.fl}) begin
            n_fail++;
            $display("FAIL clear_final: got chk=%0d err=%0d ferr=%h pass=%0b fail=%0b, want chk=%0d err=%0d ferr=%h pass=%0b fail=%0b",
                     chk_cnt, err_cnt, first_err, pass, fail, e.chk, e.err, e.ferr, e.pas, e.fl);
        end
    endtask

    task automatic test_en_gap();
        do_reset();
        exp_q.push_back('{16'd100, 16'd0, 16'hFFFF, 1'b1, 1'b0});
        for (int k = 0; k < 300 && !done; k++) begin
            drive_edge(!((edge_i >= 30) && (edge_i <= 39)), 1'b0, 1'b0, 1'b0, -1);
            if (edge_i == 30 || edge_i == 40 || edge_i == 41) begin
                n_checks++;
                if (chk_cnt !== ((edge_i == 41) ? 16'd28 : 16'd27) || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL gap_count_e%0d: got chk=%0d busy=%0b, want chk=%0d busy=1", edge_i - 1, chk_cnt, busy,
                             (edge_i == 41) ? 28 : 27);
                end
            end
        end
        n_checks++;
        if (edge_i != 113) begin
            n_fail++;
            $display("FAIL gap_done_edge: got done after %0d edges, want 113", edge_i);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({chk_cnt, err_cnt, first_err, pass, fail} !== {e.chk, e.err, e.ferr, e.pas, e.fl}) begin
            n_fail++;
            $display("FAIL gap_final: got chk=%0d err=%0d ferr=%h pass=%0b fail=%0b, want chk=%0d err=%0d ferr=%h pass=%0b fail=%0b",
                     chk_cnt, err_cnt, first_err, pass, fail, e.chk, e.err, e.ferr, e.pas, e.fl);
        end
    endtask

    task automatic test_final_mismatch();
        do_reset();
        exp_q.push_back('{16'd100, 16'd1, 16'd99, 1'b0, 1'b1});
        for (int k = 0; k < 300 && !done; k++) begin
            drive_edge(1'b1, 1'b0, 1'b0, edge_i == 102, -1);
        end
        n_checks++;
        if (edge_i != 103 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL last_done_edge: got done=%0b after %0d edges, want done=1 after 103", done, edge_i);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({chk_cnt, err_cnt, first_err, pass, fail} !== {e.chk, e.err, e.ferr, e.pas, e.fl}) begin
            n_fail++;
            $display("FAIL last_final: got chk=%0d err=%0d ferr=%0d pass=%0b fail=%0b, want chk=%0d err=%0d ferr=%0d pass=%0b fail=%0b",
                     chk_cnt, err_cnt, first_err, pass, fail, e.chk, e.err, e.ferr, e.pas, e.fl);
        end
    endtask

    task automatic test_stop_on_fail();
        do_reset();
        exp_q.push_back('{16'd5, 16'd1, 16'd4, 1'b0, 1'b1});
        for (int k = 0; k < 50 && !done_s; k++) begin
            drive_edge(1'b0, 1'b1, 1'b0, edge_i == 7, -1);
        end
        n_checks++;
        if (edge_i != 8 || done_s !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_done_edge: got done=%0b after %0d edges, want done=1 after 8", done_s, edge_i);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({chk_cnt_s, err_cnt_s, first_err_s, pass_s, fail_s} !== {e.chk, e.err, e.ferr, e.pas, e.fl}) begin
            n_fail++;
            $display("FAIL stop_final: got chk=%0d err=%0d ferr=%0d pass=%0b fail=%0b, want chk=%0d err=%0d ferr=%0d pass=%0b fail=%0b",
                     chk_cnt_s, err_cnt_s, first_err_s, pass_s, fail_s, e.chk, e.err, e.ferr, e.pas, e.fl);
        end
        for (int k = 0; k < 10; k++) begin
            drive_edge(1'b0, 1'b1, 1'b0, 1'b1, -1);
        end
        n_checks++;
        if ({chk_cnt_s, err_cnt_s, first_err_s, done_s, busy_s} !== {e.chk, e.err, e.ferr, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL stop_frozen: got chk=%0d err=%0d ferr=%0d done=%0b busy=%0b, want chk=%0d err=%0d ferr=%0d done=1 busy=0",
                     chk_cnt_s, err_cnt_s, first_err_s, done_s, busy_s, e.chk, e.err, e.ferr);
        end
        n_checks++;
        if (chk_cnt !== 16'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_main_idle: got chk=%0d busy=%0b on disabled instance, want 0 0", chk_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive_edge(1'b1, 1'b0, 1'b0, edge_i == 10, -1);
        end
        n_checks++;
        if (fail !== 1'b1 || first_err !== 16'd7 || chk_cnt !== 16'd17) begin
            n_fail++;
            $display("FAIL rstmid_pre: got fail=%0b ferr=%0d chk=%0d, want 1 7 17", fail, first_err, chk_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, fail, pass, chk_cnt, err_cnt, first_err} !== {4'b0000, 16'd0, 16'd0, 16'hFFFF}) begin
            n_fail++;
            $display("FAIL rstmid_async: got busy=%0b done=%0b fail=%0b pass=%0b chk=%0d err=%0d ferr=%h, want 0 0 0 0 0 0 ffff",
                     busy, done, fail, pass, chk_cnt, err_cnt, first_err);
        end
        #1;
        rst_n = 1'b1;
        edge_i = 0;
        exp_q.push_back('{16'd100, 16'd0, 16'hFFFF, 1'b1, 1'b0});
        for (int k = 0; k < 300 && !done; k++) begin
            drive_edge(1'b1, 1'b0, 1'b0, 1'b0, -1);
            if (edge_i == 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rstmid_restart: got busy=%0b after first edge, want 1", busy);
                end
            end
        end
        n_checks++;
        if (edge_i != 103) begin
            n_fail++;
            $display("FAIL rstmid_done_edge: got done after %0d edges, want 103", edge_i);
        end
        e = exp_q.pop_front();
        n_checks++;
        if ({chk_cnt, err_cnt, first_err, pass, fail} !== {e.chk, e.err, e.ferr, e.pas, e.fl}) begin
            n_fail++;
            $display("FAIL rstmid_final: got chk=%0d err=%0d ferr=%h pass=%0b fail=%0b, want chk=%0d err=%0d ferr=%h pass=%0b fail=%0b",
                     chk_cnt, err_cnt, first_err, pass, fail, e.chk, e.err, e.ferr, e.pas, e.fl);
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_inject37();
        test_clear();
        test_en_gap();
        test_final_mismatch();
        test_stop_on_fail();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
